// File: rtl/bus_dtack_gen_if.sv
// 68000 bus-side signals seen by the DTACK/BERR responder.
// master: CPU/decoder side (drives strobes and selects, receives acknowledges).
// slave : the responder itself.
interface bus_dtack_gen_if;
  logic as;           // address strobe, active low
  logic ram_cs;       // RAM select, active low
  logic rom_cs;       // ROM select, active low
  logic duart_cs;     // DUART select, active low
  logic duart_dtack;  // DTACK coming back from the DUART, active low
  logic dtack;        // DTACK to the CPU, active low
  logic berr;         // BERR to the CPU, active low
  logic busy;         // high while a bus cycle is being handled

  modport master (
    output as, ram_cs, rom_cs, duart_cs, duart_dtack,
    input  dtack, berr, busy
  );

  modport slave (
    input  as, ram_cs, rom_cs, duart_cs, duart_dtack,
    output dtack, berr, busy
  );
endinterface

// File: rtl/bus_dtack_gen.sv
// Bus-cycle responder for a 68000 system.
// Recognises a new cycle on the falling edge of the registered AS, then:
//   RAM / ROM : asserts DTACK after RAM_WAIT / ROM_WAIT wait states,
//   DUART     : relays the DUART's DTACK with one clock of latency,
//   nothing   : never acknowledges.
// Optional watchdog: define BUS_BERR_WATCHDOG_EN to end hung or unclaimed
// cycles with BERR after BERR_CYCLES clocks. Without it BERR is tied high.
module bus_dtack_gen #(
  parameter int RAM_WAIT    = 0,
  parameter int ROM_WAIT    = 2,
  parameter int BERR_CYCLES = 64,
  parameter int CNT_W       = 8
) (
  input  logic           clk_in,
  input  logic           reset,   // asynchronous, active low
  bus_dtack_gen_if.slave bus
);

  // Refuse to build with parameters that do not fit the counters.
  if (CNT_W < 1 || CNT_W > 31 ||
      RAM_WAIT < 0 || RAM_WAIT >= (1 << CNT_W) ||
      ROM_WAIT < 0 || ROM_WAIT >= (1 << CNT_W) ||
      BERR_CYCLES < 1 || BERR_CYCLES > (1 << CNT_W)) begin : g_bad_params
    $error("bus_dtack_gen: wait/watchdog parameters do not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] RAM_LOAD = CNT_W'(RAM_WAIT);
  localparam logic [CNT_W-1:0] ROM_LOAD = CNT_W'(ROM_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RELAY,
    S_ACK,
    S_NOSEL,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dtack_q, dtack_d;
  logic             as_q;        // AS one clock ago, for edge detection
  logic             dd_q;        // DUART DTACK one clock ago

`ifdef BUS_BERR_WATCHDOG_EN
  // Timeout fires when the watchdog reaches BERR_CYCLES-1 on this edge.
  localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(BERR_CYCLES - 1);

  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             berr_q, berr_d;
`endif

  // Input sampling: AS and the DUART acknowledge, one register each.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      as_q <= 1'b1;
      dd_q <= 1'b1;
    end else begin
      as_q <= bus.as;
      dd_q <= bus.duart_dtack;
    end
  end

  // State, wait counter and registered bus outputs.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dtack_q <= 1'b1;
`ifdef BUS_BERR_WATCHDOG_EN
      wdog_q  <= '0;
      berr_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dtack_q <= dtack_d;
`ifdef BUS_BERR_WATCHDOG_EN
      wdog_q  <= wdog_d;
      berr_q  <= berr_d;
`endif
    end
  end

  // Next-state and output decode for the bus-cycle sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dtack_d = dtack_q;
`ifdef BUS_BERR_WATCHDOG_EN
    wdog_d  = wdog_q;
    berr_d  = berr_q;
`endif

    case (state_q)
      S_IDLE: begin
        dtack_d = 1'b1;
`ifdef BUS_BERR_WATCHDOG_EN
        berr_d  = 1'b1;
`endif
        // A cycle starts only on a high-to-low AS transition, so holding
        // AS low after an acknowledge never re-triggers.
        if (!bus.as && as_q) begin
`ifdef BUS_BERR_WATCHDOG_EN
          wdog_d = '0;
`endif
          if (!bus.ram_cs) begin
            state_d = S_WAIT;
            cnt_d   = RAM_LOAD;
          end else if (!bus.rom_cs) begin
            state_d = S_WAIT;
            cnt_d   = ROM_LOAD;
          end else if (!bus.duart_cs) begin
            state_d = S_RELAY;
          end else begin
            state_d = S_NOSEL;
          end
        end
      end

      S_WAIT: begin
        if (bus.as) begin
          state_d = S_IDLE;
          dtack_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_ACK;
          dtack_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_RELAY: begin
        if (bus.as) begin
          state_d = S_IDLE;
          dtack_d = 1'b1;
        end else begin
          dtack_d = dd_q;
          if (!dd_q) begin
            state_d = S_ACK;
          end
        end
      end

      S_ACK: begin
        if (bus.as) begin
          state_d = S_IDLE;
          dtack_d = 1'b1;
        end else begin
          dtack_d = 1'b0;
        end
      end

      S_NOSEL: begin
        if (bus.as) begin
          state_d = S_IDLE;
          dtack_d = 1'b1;
        end
      end

`ifdef BUS_BERR_WATCHDOG_EN
      S_ERR: begin
        dtack_d = 1'b1;
        if (bus.as) begin
          state_d = S_IDLE;
          berr_d  = 1'b1;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        dtack_d = 1'b1;
      end
    endcase

`ifdef BUS_BERR_WATCHDOG_EN
    // Watchdog runs while a cycle waits for an acknowledge. An acknowledge
    // on the same edge as the timeout takes precedence.
    if (!bus.as && (state_q == S_WAIT || state_q == S_RELAY || state_q == S_NOSEL)) begin
      wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;
      if (state_d != S_ACK && wdog_d >= WDOG_LIMIT) begin
        state_d = S_ERR;
        berr_d  = 1'b0;
        dtack_d = 1'b1;
      end
    end
`endif
  end

  assign bus.dtack = dtack_q;
  assign bus.busy  = (state_q != S_IDLE);
`ifdef BUS_BERR_WATCHDOG_EN
  assign bus.berr  = berr_q;
`else
  assign bus.berr  = 1'b1;
`endif

endmodule

// File: tb/tb_bus_dtack_gen.sv
// Testbench for bus_dtack_gen: directed bus cycles, a cycle-level reference
// model, and literal expectations at the interesting edges.
// Honours BUS_BERR_WATCHDOG_EN the same way the design does.
module tb_bus_dtack_gen;
  localparam int RAM_WAIT    = 0;
  localparam int ROM_WAIT    = 2;
  localparam int BERR_CYCLES = 64;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   ack_count;
  int   a0;

  bus_dtack_gen_if bus ();

  bus_dtack_gen #(
    .RAM_WAIT   (RAM_WAIT),
    .ROM_WAIT   (ROM_WAIT),
    .BERR_CYCLES(BERR_CYCLES),
    .CNT_W      (8)
  ) dut (
    .clk_in(clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks a cycle by its kind and its age in clocks since the starting edge.
  // kind: 0 RAM, 1 ROM, 2 DUART, 3 unclaimed
  bit m_active, m_acked, m_timeout, m_as_prev, m_dd_prev;
  int m_kind, m_age;
  bit m_dtack, m_berr, m_busy;

  task automatic model_reset();
    m_active  = 1'b0;
    m_acked   = 1'b0;
    m_timeout = 1'b0;
    m_as_prev = 1'b1;
    m_dd_prev = 1'b1;
    m_age     = 0;
    m_kind    = 3;
    m_dtack   = 1'b1;
    m_berr    = 1'b1;
    m_busy    = 1'b0;
  endtask

  task automatic model_step();
    if (!m_active) begin
      if (!bus.as && m_as_prev) begin
        m_active  = 1'b1;
        m_age     = 0;
        m_acked   = 1'b0;
        m_timeout = 1'b0;
        m_kind    = !bus.ram_cs ? 0 : !bus.rom_cs ? 1 : !bus.duart_cs ? 2 : 3;
      end
    end else if (bus.as) begin
      m_active = 1'b0;
    end else begin
      m_age = m_age + 1;
      if (!m_acked && !m_timeout) begin
        if (m_kind == 0 && m_age >= RAM_WAIT + 1) m_acked = 1'b1;
        if (m_kind == 1 && m_age >= ROM_WAIT + 1) m_acked = 1'b1;
        if (m_kind == 2 && !m_dd_prev)            m_acked = 1'b1;
`ifdef BUS_BERR_WATCHDOG_EN
        if (!m_acked && m_age >= BERR_CYCLES - 1) m_timeout = 1'b1;
`endif
      end
    end
    m_as_prev = bus.as;
    m_dd_prev = bus.duart_dtack;
    m_dtack   = !(m_active && m_acked);
    m_berr    = !(m_active && m_timeout);
    m_busy    = m_active;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  // Every cycle out of reset, the DUT outputs must match the model.
  always @(negedge clk) begin
    if (reset) begin
      chk1("model_dtack", bus.dtack, m_dtack);
      chk1("model_berr",  bus.berr,  m_berr);
      chk1("model_busy",  bus.busy,  m_busy);
      if (!bus.dtack && !bus.berr) chk1("dtack_berr_excl", 1'b0, 1'b1);
    end
  end

  // Count acknowledges issued to the CPU.
  always @(negedge bus.dtack) begin
    if (reset) ack_count = ack_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic bus_idle();
    bus.as          = 1'b1;
    bus.ram_cs      = 1'b1;
    bus.rom_cs      = 1'b1;
    bus.duart_cs    = 1'b1;
    bus.duart_dtack = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    ack_count = 0;
    reset     = 1'b0;
    bus_idle();
    repeat (3) tick();
    chk1("rst_dtack", bus.dtack, 1'b1);
    chk1("rst_berr",  bus.berr,  1'b1);
    chk1("rst_busy",  bus.busy,  1'b0);
    reset = 1'b1;
    repeat (2) tick();

    // RAM, zero wait states: DTACK one edge after the start edge
    a0 = ack_count;
    bus.as = 1'b0; bus.ram_cs = 1'b0;
    tick();
    chk1("ram_k_dtack", bus.dtack, 1'b1);
    chk1("ram_k_busy",  bus.busy,  1'b1);
    tick();
    chk1("ram_k1_dtack", bus.dtack, 1'b0);
    repeat (3) tick();
    chk1("ram_hold_dtack", bus.dtack, 1'b0);
    bus.as = 1'b1; bus.ram_cs = 1'b1;
    tick();
    chk1("ram_end_dtack", bus.dtack, 1'b1);
    chk1("ram_end_busy",  bus.busy,  1'b0);
    chkn("ram_acks", ack_count - a0, 1);

    // ROM, two wait states, AS held low well past the acknowledge
    a0 = ack_count;
    bus.as = 1'b0; bus.rom_cs = 1'b0;
    tick();
    chk1("rom_k_dtack", bus.dtack, 1'b1);
    tick();
    chk1("rom_k1_dtack", bus.dtack, 1'b1);
    tick();
    chk1("rom_k2_dtack", bus.dtack, 1'b1);
    tick();
    chk1("rom_k3_dtack", bus.dtack, 1'b0);
    repeat (5) tick();
    chk1("rom_hold_dtack", bus.dtack, 1'b0);
    chkn("rom_acks", ack_count - a0, 1);
    bus.as = 1'b1; bus.rom_cs = 1'b1;
    tick();
    chk1("rom_end_busy", bus.busy, 1'b0);

    // Back-to-back, RAM and ROM both selected: RAM has priority
    bus.as = 1'b0; bus.ram_cs = 1'b0; bus.rom_cs = 1'b0;
    tick();
    tick();
    chk1("prio_ram_dtack", bus.dtack, 1'b0);
    bus_idle();
    tick();

    // DUART relay: DUART DTACK sampled at k+5, CPU DTACK at k+6
    a0 = ack_count;
    bus.as = 1'b0; bus.duart_cs = 1'b0;
    tick();
    repeat (4) tick();
    chk1("duart_k4_dtack", bus.dtack, 1'b1);
    bus.duart_dtack = 1'b0;
    tick();
    chk1("duart_k5_dtack", bus.dtack, 1'b1);
    tick();
    chk1("duart_k6_dtack", bus.dtack, 1'b0);
    bus_idle();
    tick();
    chk1("duart_end_dtack", bus.dtack, 1'b1);
    chk1("duart_end_busy",  bus.busy,  1'b0);
    chkn("duart_acks", ack_count - a0, 1);

    // Unclaimed cycle: watchdog BERR at k+63 (if built), never DTACK
    a0 = ack_count;
    bus.as = 1'b0;
    tick();
    repeat (62) tick();
    chk1("nosel_k62_berr", bus.berr, 1'b1);
    tick();
`ifdef BUS_BERR_WATCHDOG_EN
    chk1("nosel_k63_berr", bus.berr, 1'b0);
`else
    chk1("nosel_k63_berr", bus.berr, 1'b1);
`endif
    chk1("nosel_k63_dtack", bus.dtack, 1'b1);
    repeat (5) tick();
    chk1("nosel_hold_busy", bus.busy, 1'b1);
    bus.as = 1'b1;
    tick();
    chk1("nosel_end_berr", bus.berr, 1'b1);
    chk1("nosel_end_busy", bus.busy, 1'b0);
    chkn("nosel_acks", ack_count - a0, 0);

    // Abort: ROM cycle with AS released after one edge, then a normal cycle
    a0 = ack_count;
    bus.as = 1'b0; bus.rom_cs = 1'b0;
    tick();
    chk1("abort_k_busy", bus.busy, 1'b1);
    bus_idle();
    tick();
    chk1("abort_busy",  bus.busy,  1'b0);
    chk1("abort_dtack", bus.dtack, 1'b1);
    tick();
    chkn("abort_acks", ack_count - a0, 0);
    bus.as = 1'b0; bus.rom_cs = 1'b0;
    tick();
    repeat (2) tick();
    chk1("after_abort_k2_dtack", bus.dtack, 1'b1);
    tick();
    chk1("after_abort_k3_dtack", bus.dtack, 1'b0);
    bus_idle();
    tick();

    // Asynchronous reset in the middle of a ROM wait
    bus.as = 1'b0; bus.rom_cs = 1'b0;
    tick();
    tick();
    chk1("rst_wait_busy_pre", bus.busy, 1'b1);
    reset = 1'b0;
    #1;
    chk1("rst_wait_busy",  bus.busy,  1'b0);
    chk1("rst_wait_dtack", bus.dtack, 1'b1);
    tick();
    bus_idle();
    reset = 1'b1;
    tick();

    // Asynchronous reset while DTACK is asserted
    bus.as = 1'b0; bus.ram_cs = 1'b0;
    tick();
    tick();
    chk1("rst_ack_dtack_pre", bus.dtack, 1'b0);
    reset = 1'b0;
    #1;
    chk1("rst_ack_dtack", bus.dtack, 1'b1);
    chk1("rst_ack_busy",  bus.busy,  1'b0);
    tick();
    bus_idle();
    reset = 1'b1;
    tick();

    // Recovery after reset
    bus.as = 1'b0; bus.ram_cs = 1'b0;
    tick();
    tick();
    chk1("recover_dtack", bus.dtack, 1'b0);
    bus_idle();
    tick();
    chk1("recover_busy", bus.busy, 1'b0);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
